axi_stream_insert_header: RTL and testbench
===========================================

// Module: axi_stream_insert_header
// PURPOSE
//  Prepends a variable-length header (1..DATA_BYTE_WD bytes) to each AXI-Stream packet.
//  Output is a byte-packed, MSB-first stream: header bytes, then payload bytes, with no gaps.
//  Sits between a packet source and a downstream AXI-Stream sink. Backpressure is honoured on all three interfaces.
// PARAMETERS
//  DATA_WD       32                     data bus width in bits, multiple of 8
//  DATA_BYTE_WD  DATA_WD/8              bytes per beat
//  BYTE_CNT_WD   $clog2(DATA_BYTE_WD)   width of byte_insert_cnt
// PORTS
//  clk              in   1             single clock, rising edge
//  rst_n            in   1             asynchronous, active-low reset
//  valid_in         in   1             payload beat valid
//  data_in          in   DATA_WD       payload data; byte [DATA_WD-1 -: 8] is sent first
//  keep_in          in   DATA_BYTE_WD  payload byte enables
//  last_in          in   1             final payload beat of the packet
//  ready_in         out  1             payload beat accepted when valid_in & ready_in
//  valid_out        out  1             output beat valid
//  data_out         out  DATA_WD       merged data, MSB byte first
//  keep_out         out  DATA_BYTE_WD  output byte enables, MSB-aligned and contiguous
//  last_out         out  1             final output beat of the packet
//  ready_out        in   1             downstream ready
//  valid_insert     in   1             header valid
//  data_insert      in   DATA_WD       header; valid bytes are the LOW-order bytes
//  keep_insert      in   DATA_BYTE_WD  header enables, LSB-aligned and contiguous (e.g. 4'b0011)
//  byte_insert_cnt  in   BYTE_CNT_WD   header byte count; 0 means DATA_BYTE_WD
//  ready_insert     out  1             header accepted when valid_insert & ready_insert
// BEHAVIOUR
//  - Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=1.
//  - States: IDLE -> (header handshake) -> PASS -> (last_in accepted, overflow) -> FLUSH -> IDLE.
//    PASS also returns directly to IDLE when the last output beat completes its handshake.
//  - IDLE: ready_insert=1 and ready_in=0. Payload presented before a header stalls; it is never dropped.
//  - Header capture: header length N = popcount(keep_insert).
//    The N low bytes of data_insert are loaded into the residue register; residue count r=N.
//  - ready_insert=0 from header acceptance until the packet's last output beat is handshaken.
//    Headers arriving in that window are held off.
//  - PASS: ready_in = !valid_out | ready_out. Payload byte count k = number of leading 1s of keep_in.
//    Non-last beats must have keep_in all ones.
//  - Per accepted beat, form concat {residue[r bytes], data_in[k bytes]} (r+k bytes total):
//    - If r+k > W: emit the top W bytes with keep all ones. The remaining r+k-W bytes become the residue.
//    - If r+k <= W: emit (only valid on the last beat) r+k bytes with keep_out = top r+k bits set,
//      last_out=1, and clear the residue.
//  - Last beat with r+k > W: emit a full beat with last_out=0 and enter FLUSH.
//    FLUSH sends the r+k-W residue bytes, MSB-aligned, with last_out=1. ready_in=0 throughout FLUSH.
//  - Unused low bytes of data_out are driven 0.
//  - Output register: one-cycle latency from input handshake to valid_out.
//    data_out, keep_out and last_out stay stable while valid_out & !ready_out.
//  - Full throughput: one beat per clock when ready_out is held at 1.
//  - N == W is legal: the output lags the payload by exactly one beat.
//  - Asynchronous reset mid-packet aborts the packet: all state clears and the block returns to IDLE.
//  - Illegal inputs are a protocol error and are not checked:
//    non-contiguous keep, a non-last beat without full keep, or byte_insert_cnt != popcount(keep_insert).
// STRUCTURE
//  - Package axis_hdr_pkg holds:
//    - constants: W, BYTE_CNT_WD;
//    - typedef for the state enum {IDLE, PASS, FLUSH};
//    - functions popcount(keep) and lead_ones(keep).
//  - One natural sub-module: axis_byte_merge (combinational residue/data concat and shift).
//    The top level holds the FSM, the residue register and the output register.
// TESTING (W=32)
//  - Exact fit: hdr 0xAABBCCDD keep 0011; data 0x11223344, then 0x55667788 keep 1100 last
//    -> 0xCCDD1122 keep F, then 0x33445566 keep F last.
//  - Overflow: same header, last beat keep 1110
//    -> 0xCCDD1122, 0x33445566, then 0x77000000 keep 1000 last. ready_in=0 during the flush beat.
//  - Full header: keep 1111 with 2 payload beats (0x1..., 0x2... keep F last)
//    -> 0xAABBCCDD, 0x11223344, 0x2... last; 3 output beats.
//  - Payload before header: valid_in=1 for 5 cycles with no header -> ready_in=0, valid_out=0.
//    Then the header is accepted and output starts with its bytes.
//  - Backpressure: ready_out toggled randomly -> output stays stable while stalled.
//    The byte sequence matches a scoreboard of header+payload bytes.
//  - Back-to-back packets with a second header presented mid-packet
//    -> second header accepted only after the first packet's last_out handshake; reset mid-packet returns to IDLE.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared constants, FSM state type and keep-vector helpers for the header inserter.
package axis_hdr_pkg;

    localparam int BUS_WD      = 32;
    localparam int W           = BUS_WD / 8;
    localparam int BYTE_CNT_WD = $clog2(W);
    localparam int CNT_WD      = BYTE_CNT_WD + 1;  // holds 0..W
    localparam int SUM_WD      = BYTE_CNT_WD + 2;  // holds 0..2W

    typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;

    function automatic logic [CNT_WD-1:0] popcount(input logic [W-1:0] keep);
        logic [CNT_WD-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++)
            if (keep[i]) n = n + CNT_WD'(1);
        return n;
    endfunction

    function automatic logic [CNT_WD-1:0] lead_ones(input logic [W-1:0] keep);
        logic [CNT_WD-1:0] n;
        logic              run;
        n   = '0;
        run = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            run = run & keep[i];
            if (run) n = n + CNT_WD'(1);
        end
        return n;
    endfunction

    // Keep vector with the top n bits set, n in 0..W.
    function automatic logic [W-1:0] top_mask(input logic [CNT_WD-1:0] n);
        logic [W-1:0] ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Combinational concat of the residue bytes with the leading payload bytes,
// split into one MSB-aligned output beat and a right-aligned leftover.
module axis_byte_merge
    import axis_hdr_pkg::*;
(
    input  logic [8*W-1:0]    res_data,
    input  logic [CNT_WD-1:0] res_cnt,
    input  logic [8*W-1:0]    in_data,
    input  logic [CNT_WD-1:0] in_cnt,
    output logic [8*W-1:0]    out_data,
    output logic [W-1:0]      out_keep,
    output logic              ovf,
    output logic [8*W-1:0]    rem_data,
    output logic [CNT_WD-1:0] rem_cnt
);

    localparam logic [SUM_WD-1:0] W_S = SUM_WD'(W);

    logic [W-1:0]      in_mask;
    logic [8*W-1:0]    in_m;
    logic [16*W-1:0]   cat;
    logic [SUM_WD-1:0] total;

    assign in_mask = top_mask(in_cnt);

    // Bytes beyond the payload count are zeroed so they never leak into the beat.
    for (genvar i = 0; i < W; i++) begin : g_byte
        assign in_m[8*i +: 8] = in_mask[i] ? in_data[8*i +: 8] : 8'h00;
    end

    assign total = SUM_WD'(res_cnt) + SUM_WD'(in_cnt);
    assign ovf   = total > W_S;

    // Residue lifted to the top of a 2W-byte window, payload placed right behind it.
    assign cat = ({res_data, {8*W{1'b0}}} << (8 * (W - int'(res_cnt))))
               | ({in_m,     {8*W{1'b0}}} >> (8 * int'(res_cnt)));

    assign out_data = cat[16*W-1 -: 8*W];
    assign out_keep = ovf ? '1 : top_mask(CNT_WD'(total));
    assign rem_cnt  = ovf ? CNT_WD'(total - W_S) : '0;
    assign rem_data = ovf ? (cat[8*W-1:0] >> (8 * (W - int'(rem_cnt)))) : '0;

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends a 1..W byte header to each AXI-Stream packet, producing a gapless
// MSB-first byte stream through a single registered output stage.
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);
    import axis_hdr_pkg::*;

    state_t                state, state_nxt;
    logic [DATA_WD-1:0]    res_q;
    logic [CNT_WD-1:0]     res_cnt_q;
    logic                  done_q;
    logic [DATA_WD-1:0]    hdr_m;
    logic [CNT_WD-1:0]     data_cnt;
    logic                  out_free, out_hs, acc_in, acc_hdr, flush_ld;
    logic [DATA_WD-1:0]    m_data, m_rem;
    logic [DATA_BYTE_WD-1:0] m_keep;
    logic                  m_ovf;
    logic [CNT_WD-1:0]     m_rem_cnt;
    logic                  unused_ok;

    // Header length is taken from keep_insert; the count is redundant on legal input.
    assign unused_ok = ^byte_insert_cnt;

    assign out_free = !valid_out || ready_out;
    assign out_hs   = valid_out && ready_out;
    assign acc_in   = valid_in && ready_in;
    assign acc_hdr  = valid_insert && ready_insert;
    assign flush_ld = (state == FLUSH) && (res_cnt_q != '0) && out_free;

    // Outside PASS the merge sees zero payload bytes, so in FLUSH it yields the residue alone.
    assign data_cnt = (state == PASS) ? lead_ones(keep_in) : '0;

    for (genvar i = 0; i < DATA_BYTE_WD; i++) begin : g_hdr
        assign hdr_m[8*i +: 8] = keep_insert[i] ? data_insert[8*i +: 8] : 8'h00;
    end

    axis_byte_merge u_merge (
        .res_data (res_q),
        .res_cnt  (res_cnt_q),
        .in_data  (data_in),
        .in_cnt   (data_cnt),
        .out_data (m_data),
        .out_keep (m_keep),
        .ovf      (m_ovf),
        .rem_data (m_rem),
        .rem_cnt  (m_rem_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (acc_hdr) state_nxt = PASS;
            PASS:    if (acc_in && last_in && m_ovf) state_nxt = FLUSH;
                     else if (out_hs && last_out)    state_nxt = IDLE;
            FLUSH:   if (out_hs && last_out)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done_q closes the payload port once the last beat is in, until the packet drains.
    always_comb begin
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        unique case (state)
            IDLE:    ready_insert = 1'b1;
            PASS:    ready_in     = !done_q && out_free;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            res_cnt_q <= '0;
            done_q    <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (acc_hdr) begin
                res_q     <= hdr_m;
                res_cnt_q <= popcount(keep_insert);
                done_q    <= 1'b0;
            end else if (acc_in) begin
                res_q     <= m_rem;
                res_cnt_q <= m_rem_cnt;
                done_q    <= last_in;
            end else if (flush_ld) begin
                res_q     <= '0;
                res_cnt_q <= '0;
            end

            if (acc_in || flush_ld) begin
                valid_out <= 1'b1;
                data_out  <= m_data;
                keep_out  <= m_keep;
                last_out  <= flush_ld || (last_in && !m_ovf);
            end else if (out_hs) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for the header inserter: hand-computed output beats per packet.
module tb_axi_stream_insert_header;

    logic        clk, rst_n;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_insert, ready_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [1:0]  byte_insert_cnt;

    int n_chk = 0, n_err = 0;
    int cyc = 0, last_cyc = 0, hdr_cyc = 0;
    logic bp_en = 1'b0;

    logic [31:0] od_q[$], ed_q[$];
    logic [3:0]  ok_q[$], ek_q[$];
    logic        ol_q[$], el_q[$];

    logic        stall_q = 1'b0;
    logic [31:0] sd_q = '0;
    logic [3:0]  sk_q = '0;

    axi_stream_insert_header dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready changes just after the edge so it is stable at the sampling negedge.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake monitor: beats are recorded at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk("stable_valid", 32'(valid_out), 1);
                chk("stable_data", data_out, sd_q);
                chk("stable_keep", 32'(keep_out), 32'(sk_q));
            end
            if (valid_out && ready_out) begin
                od_q.push_back(data_out);
                ok_q.push_back(keep_out);
                ol_q.push_back(last_out);
                if (last_out) last_cyc <= cyc + 1;
            end
            stall_q <= valid_out && !ready_out;
            sd_q    <= data_out;
            sk_q    <= keep_out;
        end
    end

    task automatic put_hdr(input logic [31:0] d, input logic [3:0] k);
        int t;
        t = 0;
        @(negedge clk);
        valid_insert    = 1'b1;
        data_insert     = d;
        keep_insert     = k;
        byte_insert_cnt = 2'($countones(k));
        while (!ready_insert && t < 300) begin @(negedge clk); t++; end
        if (!ready_insert) chk("hdr_wait", 32'(ready_insert), 1);
        hdr_cyc = cyc + 1;
        @(posedge clk);
        #1 valid_insert = 1'b0;
    endtask

    task automatic put_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (!ready_in && t < 300) begin @(negedge clk); t++; end
        if (!ready_in) chk("beat_wait", 32'(ready_in), 1);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic expb(input logic [31:0] d, input logic [3:0] k, input logic l);
        ed_q.push_back(d);
        ek_q.push_back(k);
        el_q.push_back(l);
    endtask

    task automatic drain(input string tag);
        int t, i;
        t = 0;
        i = 0;
        while (od_q.size() < ed_q.size() && t < 600) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        chk({tag, "_beats"}, od_q.size(), ed_q.size());
        while (od_q.size() > 0 && ed_q.size() > 0) begin
            chk($sformatf("%s_data%0d", tag, i), od_q[0], ed_q[0]);
            chk($sformatf("%s_keep%0d", tag, i), 32'(ok_q[0]), 32'(ek_q[0]));
            chk($sformatf("%s_last%0d", tag, i), 32'(ol_q[0]), 32'(el_q[0]));
            void'(od_q.pop_front()); void'(ok_q.pop_front()); void'(ol_q.pop_front());
            void'(ed_q.pop_front()); void'(ek_q.pop_front()); void'(el_q.pop_front());
            i++;
        end
        od_q.delete(); ok_q.delete(); ol_q.delete();
        ed_q.delete(); ek_q.delete(); el_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", 32'(keep_out), 0);
        chk("rst_last_out", 32'(last_out), 0);
        chk("rst_ready_in", 32'(ready_in), 0);
        chk("rst_ready_insert", 32'(ready_insert), 1);
        rst_n = 1'b1;

        // exact fit: 2 header + 6 payload bytes = two full beats
        put_hdr(32'hAABBCCDD, 4'b0011);
        put_beat(32'h11223344, 4'hF, 1'b0);
        put_beat(32'h55667788, 4'b1100, 1'b1);
        expb(32'hCCDD1122, 4'hF, 1'b0);
        expb(32'h33445566, 4'hF, 1'b1);
        drain("fit");

        // overflow: 2 + 7 bytes spill one byte into a flush beat
        put_hdr(32'hAABBCCDD, 4'b0011);
        put_beat(32'h11223344, 4'hF, 1'b0);
        put_beat(32'h55667788, 4'b1110, 1'b1);
        @(negedge clk);
        chk("flush_ready_in", 32'(ready_in), 0);
        chk("flush_ready_insert", 32'(ready_insert), 0);
        expb(32'hCCDD1122, 4'hF, 1'b0);
        expb(32'h33445566, 4'hF, 1'b0);
        expb(32'h77000000, 4'b1000, 1'b1);
        drain("ovf");

        // full-width header: output lags payload by one beat
        put_hdr(32'hAABBCCDD, 4'b1111);
        put_beat(32'h11223344, 4'hF, 1'b0);
        put_beat(32'h55667788, 4'hF, 1'b1);
        expb(32'hAABBCCDD, 4'hF, 1'b0);
        expb(32'h11223344, 4'hF, 1'b0);
        expb(32'h55667788, 4'hF, 1'b1);
        drain("fullhdr");

        // payload presented before any header must stall, not drop
        fork
            put_beat(32'h11223344, 4'hF, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("early_ready_in", 32'(ready_in), 0);
                    chk("early_valid_out", 32'(valid_out), 0);
                end
                put_hdr(32'hAABBCCDD, 4'b0001);
            end
        join
        expb(32'hDD112233, 4'hF, 1'b0);
        expb(32'h44000000, 4'b1000, 1'b1);
        drain("early");

        // random downstream backpressure, 3 + 14 bytes
        bp_en = 1'b1;
        put_hdr(32'h00A1A2A3, 4'b0111);
        put_beat(32'h01020304, 4'hF, 1'b0);
        put_beat(32'h05060708, 4'hF, 1'b0);
        put_beat(32'h090A0B0C, 4'hF, 1'b0);
        put_beat(32'h0D0E0F10, 4'b1100, 1'b1);
        expb(32'hA1A2A301, 4'hF, 1'b0);
        expb(32'h02030405, 4'hF, 1'b0);
        expb(32'h06070809, 4'hF, 1'b0);
        expb(32'h0A0B0C0D, 4'hF, 1'b0);
        expb(32'h0E000000, 4'b1000, 1'b1);
        drain("bp");
        bp_en = 1'b0;
        repeat (2) @(negedge clk);

        // second header held off until the first packet's last beat is taken
        put_hdr(32'hAABBCCDD, 4'b0011);
        fork
            begin
                put_beat(32'h11223344, 4'hF, 1'b0);
                put_beat(32'h55667788, 4'b1100, 1'b1);
            end
            put_hdr(32'h000000EE, 4'b0001);
        join
        chk("hdr2_cycle", hdr_cyc, last_cyc + 1);
        put_beat(32'h12345678, 4'hF, 1'b1);
        expb(32'hCCDD1122, 4'hF, 1'b0);
        expb(32'h33445566, 4'hF, 1'b1);
        expb(32'hEE123456, 4'hF, 1'b0);
        expb(32'h78000000, 4'b1000, 1'b1);
        drain("b2b");

        // reset mid-packet, then a clean packet
        put_hdr(32'hAABBCCDD, 4'b0011);
        put_beat(32'h11223344, 4'hF, 1'b0);
        expb(32'hCCDD1122, 4'hF, 1'b0);
        drain("abort");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid_out", 32'(valid_out), 0);
        chk("mid_rst_ready_in", 32'(ready_in), 0);
        chk("mid_rst_ready_insert", 32'(ready_insert), 1);
        rst_n = 1'b1;
        put_hdr(32'h0000BEEF, 4'b0011);
        put_beat(32'hCAFEF00D, 4'hF, 1'b1);
        expb(32'hBEEFCAFE, 4'hF, 1'b0);
        expb(32'hF00D0000, 4'b1100, 1'b1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
